mix_state_folder: RTL and testbench
===================================

// Module: mix_state_folder
// PURPOSE
//   Downstream consumer of the 8 x 32-bit mixing-state registers (o0..o7).
//   Takes a snapshot of all words through a valid/ready handshake.
//   Serially folds the words into one 32-bit digest, one word per clock.
//   Presents the digest on a second valid/ready handshake and counts the digests it has delivered.
// PARAMETERS
//   N_WORDS   8             number of 32-bit words per snapshot (index width = $clog2(N_WORDS))
//   ROT       3             left-rotate amount applied per fold step (0..31)
//   SEED      32'h00000000  accumulator start value for every snapshot
// PORTS
//   clk          in   1            rising-edge clock
//   rst          in   1            asynchronous reset, active high
//   in_valid     in   1            snapshot on in_data is valid
//   in_ready     out  1            block can accept a snapshot
//   in_data      in   32*N_WORDS   word i = in_data[32*i +: 32] (word 0 = o0)
//   out_valid    out  1            digest on out_data is valid
//   out_ready    in   1            consumer accepts the digest
//   out_data     out  32           folded digest
//   busy         out  1            high in the FOLD state
//   digest_count out  16           number of digests delivered; wraps modulo 2^16
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0,
//     digest_count=0, idx=0, acc=0, snapshot buffer=0.
//   FSM IDLE -> FOLD -> DONE -> IDLE. All transitions occur on the rising edge of clk.
//   IDLE
//     - in_ready=1.
//     - On in_valid&&in_ready: capture in_data into the buffer, acc<=SEED, idx<=0, go to FOLD.
//     - in_data is sampled only on this edge; later changes to in_data are ignored.
//   FOLD
//     - in_ready=0, busy=1.
//     - Each edge: acc <= rotl32(acc,ROT) ^ buf[idx]; idx <= idx+1.
//     - The edge that processes idx==N_WORDS-1 also sets state=DONE and out_valid=1.
//     - out_data continuously equals acc.
//   DONE
//     - out_valid=1. out_data is held stable while out_valid=1 && !out_ready.
//     - On out_valid&&out_ready: out_valid<=0, digest_count<=digest_count+1, go to IDLE.
//   Latency: accept edge T -> out_valid high after edge T+N_WORDS, i.e. T+8 at the defaults.
//   Throughput: at most one snapshot per N_WORDS+2 cycles; there is no overlap of input and output.
//   in_ready is 0 in both FOLD and DONE. in_valid is ignored there; the upstream holds its data.
//   A DONE->IDLE edge never accepts a new snapshot; the next accept is the following edge at the earliest.
//   Arithmetic rules
//     - rotl32 is a 32-bit rotate: bits shifted out at bit 31 re-enter at bit 0.
//     - XOR has no carries. No widening or truncation takes place.
//   digest_count wraps from 16'hFFFF to 16'h0000 with no flag.
//   rst asserted mid-FOLD or mid-DONE aborts the snapshot. No digest is produced and the count does not increment.
//   out_ready while out_valid=0 has no effect.
//   X on in_data while in_valid=0 must not propagate into any state.
// TESTING
//   1. Reset, then all-zero snapshot with out_ready=1 -> out_valid after 8 edges, out_data=0, count=1.
//   2. Words w[i]=i (i=0..7), SEED=0, ROT=3 -> out_data=32'h00053977.
//   3. Rotate wrap: w0=32'h80000000, rest 0 -> out_data=32'h00100000.
//      w7=32'hFFFFFFFF, rest 0 -> out_data=32'hFFFFFFFF.
//   4. Backpressure: hold out_ready=0 for 5 cycles in DONE ->
//      out_data stable, in_ready=0, count unchanged; count increments on the 1st out_ready=1 edge.
//   5. Assert rst at FOLD idx=4 -> all outputs return to reset values at once; the next snapshot digest is correct.
//   6. Force digest_count=16'hFFFF and deliver one digest -> digest_count=16'h0000.
//      Also hold in_valid high during FOLD with changing data -> the digest matches the data captured at accept.

Source files
------------

// File: rtl/mix_state_folder_if.sv
// Snapshot-in / digest-out handshake bundle for mix_state_folder.
// The master side is the upstream producer and downstream consumer together.
interface mix_state_folder_if #(
    parameter int N_WORDS = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [32*N_WORDS-1:0]   in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mix_state_folder.sv
// Snapshots N_WORDS mixing-state words, folds them one per clock with
// rotate-and-xor into a 32-bit digest, and hands the digest out.
module mix_state_folder #(
    parameter int          N_WORDS = 8,
    parameter int          ROT     = 3,
    parameter logic [31:0] SEED    = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    mix_state_folder_if.slave    bus,
    output logic                 busy,
    output logic [15:0]          digest_count
);
    localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, FOLD, DONE} state_t;

    state_t                   state, state_d;
    logic [N_WORDS-1:0][31:0] snap;
    logic [IDX_W-1:0]         idx;
    logic [31:0]              acc;
    logic [15:0]              count;
    logic                     accept, deliver, last;

    function automatic logic [31:0] rotl(input logic [31:0] v);
        logic [63:0] t;
        t = {v, v} << ROT;
        return t[63:32];
    endfunction

    always_comb begin
        state_d       = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        accept        = 1'b0;
        deliver       = 1'b0;
        last          = (idx == IDX_W'(N_WORDS - 1));
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                if (accept) state_d = FOLD;
            end
            FOLD: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                deliver       = bus.out_ready;
                if (deliver) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // in_data is only sampled on the accept edge so an idle bus never leaks in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap  <= '0;
            idx   <= '0;
            acc   <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                snap <= bus.in_data;
                acc  <= SEED;
                idx  <= '0;
            end
            if (state == FOLD) begin
                acc <= rotl(acc) ^ snap[idx];
                idx <= idx + IDX_W'(1);
            end
            if (deliver) count <= count + 16'd1;
        end
    end

    assign bus.out_data = acc;
    assign digest_count = count;
endmodule

// File: tb/tb_mix_state_folder.sv
// Randomized self-checking bench for mix_state_folder against a plain
// arithmetic fold model.
module tb_mix_state_folder;
    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [15:0] digest_count;
    int          vecs = 0;
    int          errs = 0;
    int          exp_count = 0;

    mix_state_folder_if #(.N_WORDS(8)) bus ();

    mix_state_folder #(.N_WORDS(8), .ROT(3), .SEED(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .digest_count (digest_count)
    );

    always #5 clk = ~clk;

    // Reference: digest = fold over words of (acc rotated left by 3) xor word
    function automatic logic [31:0] model_fold(input logic [255:0] d);
        logic [31:0] a;
        a = 32'h0;
        for (int i = 0; i < 8; i++)
            a = ((a << 3) | (a >> 29)) ^ d[32*i +: 32];
        return a;
    endfunction

    function automatic logic [255:0] rand_words();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input logic [255:0] d);
        int n;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        vecs++;
        if (!bus.in_ready) begin
            errs++;
            $display("FAIL send_timeout in_ready=%0b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = {8{32'hDEAD_BEEF}};
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        vecs++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 ||
            busy !== 1'b0 || digest_count !== 16'h0) begin
            errs++;
            $display("FAIL reset rdy=%0b vld=%0b data=%h busy=%0b cnt=%h required 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data, busy, digest_count);
        end
    endtask

    task automatic test_zero_snapshot();
        int lat;
        send('0);
        wait_valid(lat);
        vecs++;
        if (lat !== 8 || bus.out_data !== 32'h0 || bus.in_ready !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL zero_digest lat=%0d data=%h rdy=%0b busy=%0b required 8 0 0 0",
                     lat, bus.out_data, bus.in_ready, busy);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_count = (exp_count + 1) & 16'hFFFF;
        vecs++;
        if (bus.out_valid !== 1'b0 || digest_count !== 16'(exp_count)) begin
            errs++;
            $display("FAIL zero_count vld=%0b cnt=%0d required 0 %0d", bus.out_valid, digest_count, exp_count);
        end
    endtask

    task automatic test_patterns();
        logic [255:0] d [3];
        logic [31:0]  want [3];
        int lat;
        for (int i = 0; i < 8; i++) d[0][32*i +: 32] = i;
        d[1] = '0; d[1][31:0]    = 32'h8000_0000;
        d[2] = '0; d[2][255:224] = 32'hFFFF_FFFF;
        want[0] = 32'h0005_3977;
        want[1] = 32'h0010_0000;
        want[2] = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            send(d[k]);
            wait_valid(lat);
            vecs++;
            if (lat !== 8 || bus.out_data !== want[k] || bus.out_data !== model_fold(d[k])) begin
                errs++;
                $display("FAIL pattern%0d lat=%0d data=%h required 8 %h", k, lat, bus.out_data, want[k]);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            exp_count = (exp_count + 1) & 16'hFFFF;
            vecs++;
            if (digest_count !== 16'(exp_count)) begin
                errs++;
                $display("FAIL pattern%0d_count cnt=%0d required %0d", k, digest_count, exp_count);
            end
        end
    endtask

    task automatic test_random();
        logic [255:0] d;
        logic [31:0]  want;
        int lat, hold;
        for (int k = 0; k < 16; k++) begin
            d    = rand_words();
            want = model_fold(d);
            send(d);
            wait_valid(lat);
            hold = $urandom_range(0, 3);
            repeat (hold) @(negedge clk);
            vecs++;
            if (lat !== 8 || bus.out_valid !== 1'b1 || bus.out_data !== want) begin
                errs++;
                $display("FAIL random%0d lat=%0d vld=%0b data=%h required 8 1 %h",
                         k, lat, bus.out_valid, bus.out_data, want);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            exp_count = (exp_count + 1) & 16'hFFFF;
            vecs++;
            if (digest_count !== 16'(exp_count) || bus.out_valid !== 1'b0) begin
                errs++;
                $display("FAIL random%0d_count cnt=%0d vld=%0b required %0d 0",
                         k, digest_count, bus.out_valid, exp_count);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] d;
        logic [31:0]  want;
        int lat;
        d    = rand_words();
        want = model_fold(d);
        send(d);
        wait_valid(lat);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.in_data = rand_words();
            @(negedge clk);
            vecs++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== want || bus.in_ready !== 1'b0 ||
                digest_count !== 16'(exp_count)) begin
                errs++;
                $display("FAIL stall%0d vld=%0b data=%h rdy=%0b cnt=%0d required 1 %h 0 %0d",
                         c, bus.out_valid, bus.out_data, bus.in_ready, digest_count, want, exp_count);
            end
        end
        // in_valid stays high across the DONE->IDLE edge, which must not accept
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        exp_count = (exp_count + 1) & 16'hFFFF;
        vecs++;
        if (digest_count !== 16'(exp_count) || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL stall_release cnt=%0d rdy=%0b busy=%0b required %0d 1 0",
                     digest_count, bus.in_ready, busy, exp_count);
        end
    endtask

    task automatic test_reset_mid_fold();
        logic [255:0] d;
        int lat;
        send(rand_words());
        repeat (4) @(negedge clk);
        vecs++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL mid_fold_busy busy=%0b required 1", busy);
        end
        rst = 1'b1;
        #1;
        exp_count = 0;
        vecs++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 ||
            busy !== 1'b0 || digest_count !== 16'h0) begin
            errs++;
            $display("FAIL mid_fold_reset rdy=%0b vld=%0b data=%h busy=%0b cnt=%h required 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data, busy, digest_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        d = rand_words();
        send(d);
        wait_valid(lat);
        vecs++;
        if (lat !== 8 || bus.out_data !== model_fold(d)) begin
            errs++;
            $display("FAIL after_reset lat=%0d data=%h required 8 %h", lat, bus.out_data, model_fold(d));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_count = (exp_count + 1) & 16'hFFFF;
    endtask

    task automatic test_count_wrap();
        int lat;
        force dut.count = 16'hFFFF;
        @(negedge clk);
        release dut.count;
        exp_count = 16'hFFFF;
        vecs++;
        if (digest_count !== 16'hFFFF) begin
            errs++;
            $display("FAIL preset_count cnt=%h required ffff", digest_count);
        end
        send('0);
        wait_valid(lat);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_count = (exp_count + 1) & 16'hFFFF;
        vecs++;
        if (digest_count !== 16'(exp_count)) begin
            errs++;
            $display("FAIL count_wrap cnt=%h required %h", digest_count, 16'(exp_count));
        end
    endtask

    task automatic test_hold_valid_fold();
        logic [255:0] d;
        int lat;
        d = rand_words();
        send(d);
        bus.in_valid = 1'b1;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            bus.in_data = rand_words();
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        vecs++;
        if (lat !== 8 || bus.out_data !== model_fold(d)) begin
            errs++;
            $display("FAIL hold_valid lat=%0d data=%h required 8 %h", lat, bus.out_data, model_fold(d));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_count = (exp_count + 1) & 16'hFFFF;
        vecs++;
        if (digest_count !== 16'(exp_count)) begin
            errs++;
            $display("FAIL hold_valid_count cnt=%0d required %0d", digest_count, exp_count);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_zero_snapshot();
        test_patterns();
        test_random();
        test_backpressure();
        test_reset_mid_fold();
        test_count_wrap();
        test_hold_valid_fold();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
